// File: rtl/id_ex_hazard_reg_if.sv
// Port bundle for the ID/EX register: decode-side fields, flush/hold controls and the
// registered EX-side copies that feed execute and the forwarding controller.
interface id_ex_hazard_reg_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   // id_valid_ip qualifies every id_* field. While if_id_stall_op is high the front end
   // must re-present the same instruction next cycle. ex_hold_ip freezes the EX copy.
   logic             id_valid_ip;
   logic [6:0]       id_instr_opcode_ip;
   logic [4:0]       id_rs1_ip;
   logic [4:0]       id_rs2_ip;
   logic [4:0]       id_rd_ip;
   logic [2:0]       id_wb_mux_ip;
   logic             id_mem_read_ip;
   logic [XLEN-1:0]  id_rs1_data_ip;
   logic [XLEN-1:0]  id_rs2_data_ip;
   logic [XLEN-1:0]  id_imm_ip;
   logic [XLEN-1:0]  id_pc_ip;
   logic             branch_flush_ip;
   logic             ex_hold_ip;
   logic             ex_valid_op;
   logic [6:0]       ex_instr_opcode_op;
   logic [4:0]       ex_rs1_op;
   logic [4:0]       ex_rs2_op;
   logic [4:0]       ex_rd_op;
   logic [2:0]       ex_wb_mux_op;
   logic             ex_mem_read_op;
   logic [XLEN-1:0]  ex_rs1_data_op;
   logic [XLEN-1:0]  ex_rs2_data_op;
   logic [XLEN-1:0]  ex_imm_op;
   logic [XLEN-1:0]  ex_pc_op;
   logic             if_id_stall_op;
   logic [CNT_W-1:0] load_use_cnt_op;

   modport master (
      output id_valid_ip, id_instr_opcode_ip, id_rs1_ip, id_rs2_ip, id_rd_ip, id_wb_mux_ip,
             id_mem_read_ip, id_rs1_data_ip, id_rs2_data_ip, id_imm_ip, id_pc_ip,
             branch_flush_ip, ex_hold_ip,
      input  ex_valid_op, ex_instr_opcode_op, ex_rs1_op, ex_rs2_op, ex_rd_op, ex_wb_mux_op,
             ex_mem_read_op, ex_rs1_data_op, ex_rs2_data_op, ex_imm_op, ex_pc_op,
             if_id_stall_op, load_use_cnt_op
   );

   modport slave (
      input  id_valid_ip, id_instr_opcode_ip, id_rs1_ip, id_rs2_ip, id_rd_ip, id_wb_mux_ip,
             id_mem_read_ip, id_rs1_data_ip, id_rs2_data_ip, id_imm_ip, id_pc_ip,
             branch_flush_ip, ex_hold_ip,
      output ex_valid_op, ex_instr_opcode_op, ex_rs1_op, ex_rs2_op, ex_rd_op, ex_wb_mux_op,
             ex_mem_read_op, ex_rs1_data_op, ex_rs2_data_op, ex_imm_op, ex_pc_op,
             if_id_stall_op, load_use_cnt_op
   );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with built-in load-use detection: inserts one bubble and stalls
// the front end when a load result is needed by the very next instruction.
module id_ex_hazard_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               reset,
   id_ex_hazard_reg_if.slave bus
);
   localparam logic [6:0] OPCODE_LOAD   = 7'h03;
   localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
   localparam logic [6:0] OPCODE_STORE  = 7'h23;
   localparam logic [6:0] OPCODE_OP     = 7'h33;
   localparam logic [6:0] OPCODE_BRANCH = 7'h63;
   localparam logic [6:0] OPCODE_JALR   = 7'h67;
   localparam logic [2:0] NO_WRITEBACK  = 3'd0;

   logic             r_valid;
   logic [6:0]       r_opcode;
   logic [4:0]       r_rs1;
   logic [4:0]       r_rs2;
   logic [4:0]       r_rd;
   logic [2:0]       r_wb_mux;
   logic             r_mem_read;
   logic [XLEN-1:0]  r_rs1_data;
   logic [XLEN-1:0]  r_rs2_data;
   logic [XLEN-1:0]  r_imm;
   logic [XLEN-1:0]  r_pc;
   logic [CNT_W-1:0] r_cnt;

   logic w_rs1_used;
   logic w_rs2_used;
   logic w_load_use;
   logic w_load_bubble;
   logic w_capture;
   logic w_count;

   always_comb begin
      w_rs1_used = 1'b0;
      w_rs2_used = 1'b0;
      case (bus.id_instr_opcode_ip)
         OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: w_rs1_used = 1'b1;
         default: ;
      endcase
   end

   // Only real register fields count: an I-type immediate can alias the rs2 field.
   assign w_load_use = r_valid && r_mem_read && (r_rd != 5'd0) && bus.id_valid_ip &&
                       !bus.branch_flush_ip &&
                       ((w_rs1_used && (bus.id_rs1_ip == r_rd)) ||
                        (w_rs2_used && (bus.id_rs2_ip == r_rd)));

   assign w_load_bubble = bus.branch_flush_ip |
                          (~bus.ex_hold_ip & (w_load_use | ~bus.id_valid_ip));
   assign w_capture     = ~bus.branch_flush_ip & ~bus.ex_hold_ip & ~w_load_use & bus.id_valid_ip;
   assign w_count       = ~bus.ex_hold_ip & w_load_use & (r_cnt != '1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_opcode   <= 7'h00;
         r_rs1      <= 5'd0;
         r_rs2      <= 5'd0;
         r_rd       <= 5'd0;
         r_wb_mux   <= NO_WRITEBACK;
         r_mem_read <= 1'b0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_load_bubble) begin
            r_valid    <= 1'b0;
            r_opcode   <= 7'h00;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_wb_mux   <= NO_WRITEBACK;
            r_mem_read <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
         end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_opcode   <= bus.id_instr_opcode_ip;
            r_rs1      <= bus.id_rs1_ip;
            r_rs2      <= bus.id_rs2_ip;
            r_rd       <= bus.id_rd_ip;
            r_wb_mux   <= bus.id_wb_mux_ip;
            r_mem_read <= bus.id_mem_read_ip;
            r_rs1_data <= bus.id_rs1_data_ip;
            r_rs2_data <= bus.id_rs2_data_ip;
            r_imm      <= bus.id_imm_ip;
            r_pc       <= bus.id_pc_ip;
         end
         if (w_count) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.ex_valid_op        = r_valid;
   assign bus.ex_instr_opcode_op = r_opcode;
   assign bus.ex_rs1_op          = r_rs1;
   assign bus.ex_rs2_op          = r_rs2;
   assign bus.ex_rd_op           = r_rd;
   assign bus.ex_wb_mux_op       = r_wb_mux;
   assign bus.ex_mem_read_op     = r_mem_read;
   assign bus.ex_rs1_data_op     = r_rs1_data;
   assign bus.ex_rs2_data_op     = r_rs2_data;
   assign bus.ex_imm_op          = r_imm;
   assign bus.ex_pc_op           = r_pc;
   assign bus.if_id_stall_op     = bus.ex_hold_ip | w_load_use;
   assign bus.load_use_cnt_op    = r_cnt;
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: directed hazard scenarios followed by random
// instruction streams, compared against an instruction-level pipeline model.
module tb_id_ex_hazard_reg;
   localparam int XLEN  = 32;
   localparam int CNT_W = 2;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_OPIMM  = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [2:0] WB_NONE   = 3'd0;
   localparam logic [2:0] WB_ALU    = 3'd1;
   localparam logic [2:0] WB_MEM    = 3'd2;
   localparam logic [2:0] WB_PC4    = 3'd3;

   typedef struct packed {
      logic            valid;
      logic [6:0]      op;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      wb;
      logic            mr;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
   } instr_t;

   typedef struct packed {
      instr_t           ex;
      logic             stall;
      logic [CNT_W-1:0] cnt;
   } obs_t;

   obs_t   exp_q[$];
   obs_t   mon_exp;
   obs_t   mon_got;
   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   instr_t m_ex;
   instr_t n_ex;
   int     m_cnt;
   int     n_cnt;

   logic clk = 1'b0;
   logic reset = 1'b1;

   // ---------------- clock / reset / DUT ----------------
   always #5 clk = ~clk;

   id_ex_hazard_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   id_ex_hazard_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- reference model helpers ----------------
   function automatic bit reads_rs1(input logic [6:0] op);
      return op inside {OP_OP, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
   endfunction

   function automatic bit reads_rs2(input logic [6:0] op);
      return op inside {OP_OP, OP_STORE, OP_BRANCH};
   endfunction

   function automatic instr_t bubble();
      instr_t b;
      b    = '0;
      b.wb = WB_NONE;
      return b;
   endfunction

   function automatic instr_t mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
      instr_t i;
      i.valid = 1'b1;
      i.op    = op;
      i.rd    = 5'(rd);
      i.rs1   = 5'(rs1);
      i.rs2   = 5'(rs2);
      i.mr    = (op == OP_LOAD);
      case (op)
         OP_LOAD:             i.wb = WB_MEM;
         OP_STORE, OP_BRANCH: i.wb = WB_NONE;
         OP_JAL, OP_JALR:     i.wb = WB_PC4;
         default:             i.wb = WB_ALU;
      endcase
      i.d1  = $urandom;
      i.d2  = $urandom;
      i.imm = $urandom;
      i.pc  = $urandom & 32'hffff_fffc;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      logic [6:0] ops [8];
      instr_t     i;
      ops = '{OP_OP, OP_OPIMM, OP_LOAD, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL};
      if ($urandom_range(0, 9) == 0) ops[7] = OP_LUI;
      i = mk(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3));
      i.valid = ($urandom_range(0, 9) != 0);
      return i;
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input instr_t id, input bit flush, input bit hold, output bit stall);
      obs_t o;
      bit   hz;
      @(posedge clk);
      #1;
      m_ex  = n_ex;
      m_cnt = n_cnt;
      cyc++;
      bus.id_valid_ip        = id.valid;
      bus.id_instr_opcode_ip = id.op;
      bus.id_rs1_ip          = id.rs1;
      bus.id_rs2_ip          = id.rs2;
      bus.id_rd_ip           = id.rd;
      bus.id_wb_mux_ip       = id.wb;
      bus.id_mem_read_ip     = id.mr;
      bus.id_rs1_data_ip     = id.d1;
      bus.id_rs2_data_ip     = id.d2;
      bus.id_imm_ip          = id.imm;
      bus.id_pc_ip           = id.pc;
      bus.branch_flush_ip    = flush;
      bus.ex_hold_ip         = hold;
      // A load in EX writing a real register that the ID instruction actually reads.
      hz = m_ex.valid && m_ex.mr && (m_ex.rd != 0) && id.valid && !flush &&
           ((reads_rs1(id.op) && id.rs1 == m_ex.rd) || (reads_rs2(id.op) && id.rs2 == m_ex.rd));
      stall   = hold || hz;
      o.ex    = m_ex;
      o.stall = stall;
      o.cnt   = CNT_W'(m_cnt);
      exp_q.push_back(o);
      if (flush) n_ex = bubble();
      else if (hold) n_ex = m_ex;
      else if (hz) begin
         n_ex = bubble();
         if (m_cnt < (1 << CNT_W) - 1) n_cnt = m_cnt + 1;
      end else n_ex = id.valid ? id : bubble();
   endtask

   task automatic idle_inputs();
      bus.id_valid_ip = 1'b0; bus.id_instr_opcode_ip = '0; bus.id_rs1_ip = '0;
      bus.id_rs2_ip = '0; bus.id_rd_ip = '0; bus.id_wb_mux_ip = WB_NONE;
      bus.id_mem_read_ip = 1'b0; bus.id_rs1_data_ip = '0; bus.id_rs2_data_ip = '0;
      bus.id_imm_ip = '0; bus.id_pc_ip = '0; bus.branch_flush_ip = 1'b0; bus.ex_hold_ip = 1'b0;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got.ex.valid = bus.ex_valid_op;
         mon_got.ex.op    = bus.ex_instr_opcode_op;
         mon_got.ex.rs1   = bus.ex_rs1_op;
         mon_got.ex.rs2   = bus.ex_rs2_op;
         mon_got.ex.rd    = bus.ex_rd_op;
         mon_got.ex.wb    = bus.ex_wb_mux_op;
         mon_got.ex.mr    = bus.ex_mem_read_op;
         mon_got.ex.d1    = bus.ex_rs1_data_op;
         mon_got.ex.d2    = bus.ex_rs2_data_op;
         mon_got.ex.imm   = bus.ex_imm_op;
         mon_got.ex.pc    = bus.ex_pc_op;
         mon_got.stall    = bus.if_id_stall_op;
         mon_got.cnt      = bus.load_use_cnt_op;
         checks++;
         if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL obs cyc=%0d got=%h exp=%h", cyc, mon_got, mon_exp);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      instr_t dep;
      instr_t cur;
      bit     st;
      int     nst;
      idle_inputs();
      m_ex = bubble(); n_ex = bubble(); m_cnt = 0; n_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(bus.ex_valid_op), 64'd0);
      check("rst_wb", 64'(bus.ex_wb_mux_op), 64'(WB_NONE));
      check("rst_stall", 64'(bus.if_id_stall_op), 64'd0);
      check("rst_cnt", 64'(bus.load_use_cnt_op), 64'd0);
      reset = 1'b0;

      // Normal capture of add x3,x1,x2
      drive(mk(OP_OP, 3, 1, 2), 0, 0, st);
      drive(bubble(), 0, 0, st);

      // Load-use on rs1: exactly one stall cycle, then the add reaches EX
      drive(mk(OP_LOAD, 5, 1, 0), 0, 0, st);
      dep = mk(OP_OP, 6, 5, 7);
      nst = 0;
      for (int k = 0; k < 4; k++) begin
         drive(dep, 0, 0, st);
         @(negedge clk); #1;
         if (bus.if_id_stall_op) nst++;
         else break;
      end
      check("lu_stall_cycles", 64'(nst), 64'd1);
      drive(bubble(), 0, 0, st);
      @(negedge clk); #1;
      check("lu_dep_in_ex", 64'(bus.ex_rd_op), 64'd6);

      // Load to x0, and an I-type whose immediate aliases rs2=5
      drive(mk(OP_LOAD, 0, 1, 0), 0, 0, st);
      drive(mk(OP_OP, 1, 0, 0), 0, 0, st);
      drive(mk(OP_LOAD, 5, 2, 0), 0, 0, st);
      drive(mk(OP_OPIMM, 6, 1, 5), 0, 0, st);

      // Flush beats a pending load-use
      drive(mk(OP_LOAD, 5, 2, 0), 0, 0, st);
      drive(mk(OP_OP, 6, 5, 5), 1, 0, st);
      drive(bubble(), 0, 0, st);

      // Hold for three cycles, then the pending instruction is captured
      drive(mk(OP_OP, 9, 1, 2), 0, 0, st);
      cur = mk(OP_STORE, 0, 3, 4);
      repeat (3) drive(cur, 0, 1, st);
      drive(cur, 0, 0, st);
      drive(bubble(), 0, 0, st);

      // Five more hazards saturate the 2-bit counter
      for (int h = 0; h < 5; h++) begin
         drive(mk(OP_LOAD, 4, 1, 0), 0, 0, st);
         dep = mk(OP_BRANCH, 0, 1, 4);
         drive(dep, 0, 0, st);
         if (st) drive(dep, 0, 0, st);
      end
      drive(bubble(), 0, 0, st);
      @(negedge clk); #1;
      check("cnt_saturated", 64'(bus.load_use_cnt_op), 64'd3);

      // Asynchronous reset in the middle of a stall
      drive(mk(OP_LOAD, 7, 1, 0), 0, 0, st);
      drive(mk(OP_OP, 8, 7, 7), 0, 0, st);
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      check("arst_valid", 64'(bus.ex_valid_op), 64'd0);
      check("arst_opcode", 64'(bus.ex_instr_opcode_op), 64'd0);
      check("arst_stall", 64'(bus.if_id_stall_op), 64'd0);
      check("arst_cnt", 64'(bus.load_use_cnt_op), 64'd0);
      idle_inputs();
      n_ex = bubble(); n_cnt = 0;
      @(posedge clk); #1;
      reset = 1'b0;

      // Random stream; a stalled instruction is re-presented like a real front end
      cur = rand_instr();
      st  = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (!st) cur = rand_instr();
         drive(cur, ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0), st);
      end

      @(negedge clk); #1;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

ID/EX pipeline register for the 5-stage RISCV core, with the load-use hazard detector built in. It captures decoded operands and control from the decode stage and presents them to execute. These registered outputs are the opcode, source registers and write-back selector that the forwarding controller consumes. When forwarding cannot cover a dependency (a load result needed by the very next instruction), the block inserts one bubble and holds the front end. It also squashes its contents on a taken-branch flush.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the load-use stall counter

Ports:
- clk  in  1  core clock, all state rising-edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_valid_ip  in  1  decode stage holds a real instruction
- id_instr_opcode_ip  in  7  decoded opcode (CORE_PKG OPCODE_* values)
- id_rs1_ip, id_rs2_ip, id_rd_ip  in  5 each  source/destination register indices
- id_wb_mux_ip  in  write_back_mux_selector  write-back source; NO_WRITEBACK = no register write
- id_mem_read_ip  in  1  instruction is a load
- id_rs1_data_ip, id_rs2_data_ip, id_imm_ip, id_pc_ip  in  XLEN each  operand data, immediate, PC
- branch_flush_ip  in  1  taken branch/jump resolved in EX; squash decode instruction
- ex_hold_ip  in  1  downstream stall (e.g. memory busy); freeze this register
- ex_valid_op, ex_instr_opcode_op, ex_rs1_op, ex_rs2_op, ex_rd_op, ex_wb_mux_op, ex_mem_read_op, ex_rs1_data_op, ex_rs2_data_op, ex_imm_op, ex_pc_op  out  matching widths  registered copies of the id_* inputs
- if_id_stall_op  out  1  hold PC and IF/ID register this cycle (combinational)
- load_use_cnt_op  out  CNT_W  saturating count of inserted load-use bubbles

## Operation
- Source-use decode of id_instr_opcode_ip:
  - rs1 used for OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR.
  - rs2 used for OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH.
  - Every other opcode uses neither.
- load_use is true when all of the following hold:
  - ex_valid_op and ex_mem_read_op are set.
  - ex_rd_op != 0.
  - id_valid_ip is set.
  - ex_rd_op equals a used source (rs1 or rs2) of the decode instruction.
  - branch_flush_ip = 0.
- Bubble contents:
  - valid=0, opcode=7'h00, rs1=rs2=rd=0, wb_mux=NO_WRITEBACK, mem_read=0.
  - Data, imm and pc = 0.
  - Opcode 0 matches no forwarding case, so downstream forwarding stays at ORIGINAL_SELECT.
- Per-edge update, highest priority first:
  1. reset: all outputs to the bubble state, counter 0.
  2. branch_flush_ip: load bubble; counter unchanged.
  3. ex_hold_ip: hold all ex_* registers; counter unchanged.
  4. load_use: load bubble; counter += 1, saturating at 2^CNT_W-1.
  5. Otherwise: capture id_* inputs; when id_valid_ip=0, capture as a bubble.
- if_id_stall_op = ex_hold_ip | load_use, evaluated after the flush gating above. A flush therefore never produces a stall.
- Writes with rd=0 are never treated as hazards.

## Timing
- Capture latency: 1 cycle from id_* to ex_*.
- if_id_stall_op is purely combinational from current id_* inputs and registered ex_* state. There is no added latency.
- Load-use sequence, load in EX at cycle N with a dependent instruction in ID:
  - N: if_id_stall_op=1.
  - N+1: EX holds the bubble and the load has moved to MEM. The stall drops because the EX content is no longer a load. The dependent instruction is still in ID.
  - N+2: the dependent instruction is in EX; its operand is forwarded from MEM/WB.
- Exactly one bubble per load-use hazard. A back-to-back dependent chain on the same load never produces a second bubble.
- Reset asserted mid-operation clears all state asynchronously. Release is synchronous to the next clk edge.
- After reset, every output is in the bubble state, if_id_stall_op=0 and load_use_cnt_op=0.
- Simultaneous events:
  - flush + load_use: flush wins; bubble loaded, no stall, no count.
  - hold + load_use: hold wins for the register, and the stall stays asserted. load_use re-evaluates in the cycle after the hold.

## Test plan
- Normal capture: id OP add x3,x1,x2 with valid=1 -> next cycle ex_instr_opcode_op=OPCODE_OP, ex_rd_op=3, ex_valid_op=1, stall=0.
- Load-use on rs1: lw x5 then add x6,x5,x7 -> stall=1 for exactly one cycle, one bubble in EX (wb_mux=NO_WRITEBACK), add in EX two cycles after the load, load_use_cnt_op=1.
- Load to x0 and unused source:
  - lw x0 followed by add x1,x0,x0 -> no stall.
  - lw x5 followed by addi x6,x1,5 (imm encoding may alias rs2=5) -> no stall.
- Flush priority: load-use condition present with branch_flush_ip=1 -> bubble loaded, stall=0, counter unchanged.
- Hold: ex_hold_ip=1 for 3 cycles -> ex_* unchanged, stall=1 each cycle. Release -> pending ID instruction captured.
- Reset and saturation:
  - Async reset mid-stall -> outputs bubble immediately, stall=0.
  - CNT_W=2 with 5 hazards -> load_use_cnt_op=3.
